mem_port_arbiter: RTL and testbench

// - Shares the single data-memory port between NUM_REQ requesters (req 0 = core load/store path, req 1 = program loader/debug).
// - Round-robin grant, one access per cycle; tags reads so read data returns only to its issuer.
// - Optional bus lock for atomic read-modify-write sequences.
// - Sits between the requesters and data_mem.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_rr_pick.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: default widths,
// lock FSM encodings and small index helpers.
package mem_port_arbiter_pkg;

    localparam int DEF_NUM_REQ  = 2;
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_RD_LAT   = 1;
    localparam int DEF_LOCK_MAX = 8;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    // Width of a requester ID; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (a + b) mod n, used to rotate into and out of pointer-relative order.
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: rotate the request vector so the pointer sits at
// bit 0, priority-encode the lowest set bit, then rotate the result back.
module mem_port_arbiter_rr_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = id_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDW-1:0]     o_id,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_rot;
    logic [IDW-1:0]     w_off;
    logic               w_found;

    // Rotate requests so the requester at the pointer becomes bit 0.
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_rot[k] = i_req[IDW'(wrap_add(int'(i_ptr), k, NUM_REQ))];
        end
    end

    // Priority-encode: lowest set bit of the rotated vector wins.
    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = IDW'(k);
            end else begin
                w_found = w_found;
                w_off   = w_off;
            end
        end
    end

    // Unrotate the winning offset back to an absolute ID and one-hot grant.
    always_comb begin
        o_gnt = '0;
        o_id  = '0;
        o_any = w_found;
        if (w_found) begin
            o_id        = IDW'(wrap_add(int'(i_ptr), int'(w_off), NUM_REQ));
            o_gnt[o_id] = 1'b1;
        end else begin
            o_id = '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between NUM_REQ requesters: round-robin
// grant, read-data tagging back to the issuer, and an optional bus lock
// with forced release after LOCK_MAX owner grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      lock_abort,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int IDW  = id_width(NUM_REQ);
    localparam int CNTW = $clog2(LOCK_MAX + 1);

    lock_state_e        r_state, w_state_nxt;
    logic [IDW-1:0]     r_owner, w_owner_nxt;
    logic [IDW-1:0]     r_ptr, w_ptr_nxt;
    logic [IDW-1:0]     r_bar_id, w_bar_id_nxt;
    logic               r_bar_vld, w_bar_vld_nxt;
    logic [CNTW-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic               r_lock_abort, w_abort_nxt;
    logic [RD_LAT-1:0]  r_tag_vld;
    logic [IDW-1:0]     r_tag_id [RD_LAT];

    logic [NUM_REQ-1:0] w_owner_oh;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IDW-1:0]     w_win_id;
    logic [IDW-1:0]     w_ptr_inc;
    logic               w_any;
    logic               w_hold;
    logic               w_may_lock;

    // Owner still asserting lock: only the owner is eligible this cycle.
    assign w_hold = (r_state == LOCK_HELD) && req_lock[r_owner];

    // One-hot mask of the current lock owner.
    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

    // Eligible requesters; nothing is eligible while reset is asserted.
    always_comb begin
        w_elig = '0;
        if (!reset) begin
            w_elig = '0;
        end else if (w_hold) begin
            w_elig = req & w_owner_oh;
        end else begin
            w_elig = req;
        end
    end

    mem_port_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_id    (w_win_id),
        .o_any   (w_any)
    );

    assign w_ptr_inc  = (w_win_id == IDW'(NUM_REQ - 1)) ? '0 : (w_win_id + IDW'(1));
    assign w_cnt_inc  = r_cnt + CNTW'(1);
    // A winner asking for lock takes it unless it was just force-released.
    assign w_may_lock = w_any && req_lock[w_win_id] &&
                        !(r_bar_vld && (w_win_id == r_bar_id));

    // Lock FSM next state, RR pointer, relock bar and abort pulse.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_cnt_nxt     = r_cnt;
        w_bar_vld_nxt = r_bar_vld;
        w_bar_id_nxt  = r_bar_id;
        w_abort_nxt   = 1'b0;

        if (w_any) begin
            w_ptr_nxt = w_ptr_inc;
        end else begin
            w_ptr_nxt = r_ptr;
        end

        if (w_any && r_bar_vld && (w_win_id != r_bar_id)) begin
            w_bar_vld_nxt = 1'b0;
        end else begin
            w_bar_vld_nxt = r_bar_vld;
        end

        case (r_state)
            LOCK_IDLE: begin
                if (w_may_lock) begin
                    w_state_nxt = LOCK_HELD;
                    w_owner_nxt = w_win_id;
                    w_cnt_nxt   = CNTW'(1);
                end else begin
                    w_state_nxt = LOCK_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            LOCK_HELD: begin
                if (!w_hold) begin
                    // Owner released: this cycle arbitrated normally.
                    if (w_may_lock) begin
                        w_state_nxt = LOCK_HELD;
                        w_owner_nxt = w_win_id;
                        w_cnt_nxt   = CNTW'(1);
                    end else begin
                        w_state_nxt = LOCK_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else if (w_any) begin
                    if (w_cnt_inc >= CNTW'(LOCK_MAX)) begin
                        w_state_nxt   = LOCK_IDLE;
                        w_cnt_nxt     = '0;
                        w_abort_nxt   = 1'b1;
                        w_bar_vld_nxt = 1'b1;
                        w_bar_id_nxt  = r_owner;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            default: begin
                w_state_nxt = LOCK_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Lock FSM and arbitration state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= LOCK_IDLE;
            r_owner      <= '0;
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_bar_vld    <= 1'b0;
            r_bar_id     <= '0;
            r_lock_abort <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ptr        <= w_ptr_nxt;
            r_bar_vld    <= w_bar_vld_nxt;
            r_bar_id     <= w_bar_id_nxt;
            r_lock_abort <= w_abort_nxt;
        end
    end

    // Read tag pipeline: issuer ID travels alongside the memory latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_any & ~req_we[w_win_id];
            r_tag_id[0]  <= w_win_id;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    // Memory-side mux driven by the current winner.
    always_comb begin
        gnt    = w_gnt;
        mem_en = w_any;
        mem_we = w_any & req_we[w_win_id];
        if (w_any) begin
            mem_addr  = req_addr[w_win_id*ADDR_W +: ADDR_W];
            mem_wdata = req_wdata[w_win_id*DATA_W +: DATA_W];
        end else begin
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // Read return: steer rvalid to the tagged issuer, zero rdata otherwise.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (r_tag_vld[RD_LAT-1]) begin
            rvalid[r_tag_id[RD_LAT-1]] = 1'b1;
            rdata                      = mem_rdata;
        end else begin
            rvalid = '0;
            rdata  = '0;
        end
    end

    assign lock_abort = r_lock_abort;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter (2 requesters,
// RD_LAT=2, LOCK_MAX=4) with a small behavioural data memory.
module tb_mem_port_arbiter;

    localparam logic [31:0] W0 = 32'hA0A0_0000;
    localparam logic [31:0] W1 = 32'hB1B1_0001;

    logic        clk;
    logic        reset;
    logic [1:0]  req, req_we, req_lock;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        lock_abort, mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [1:0]  lock;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  gnt;
        logic [1:0]  rvalid;
        logic [31:0] rdata;
        logic        abort;
    } vec_t;

    vec_t tbl [25];

    mem_port_arbiter #(
        .NUM_REQ  (2),
        .ADDR_W   (32),
        .DATA_W   (32),
        .RD_LAT   (2),
        .LOCK_MAX (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_we     (req_we),
        .req_lock   (req_lock),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .lock_abort (lock_abort),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: 64 words, 2-cycle read latency.
    logic [31:0] mem_arr [64];
    logic        mem_loaded = 1'b0;
    logic [31:0] rd_p0, rd_p1;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) begin
                mem_arr[i] <= 32'h1000_0000 + 32'(i);
            end
            mem_arr[16] <= 32'hDEAD_BEEF;
            mem_arr[17] <= 32'h1234_5678;
            mem_loaded  <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem_arr[mem_addr[7:2]] <= mem_wdata;
        end
        rd_p0 <= (mem_en && !mem_we) ? mem_arr[mem_addr[7:2]] : 32'h0;
        rd_p1 <= rd_p0;
    end
    assign mem_rdata = rd_p1;

    function automatic vec_t mk(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [1:0] g, input logic [1:0] rv,
                                input logic [31:0] rd, input logic ab);
        vec_t v;
        v.req = r; v.we = w; v.lock = l; v.a0 = a0; v.a1 = a1;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.abort = ab;
        return v;
    endfunction

    task automatic check(input string name, input vec_t v);
        logic        e_en, e_we;
        logic [31:0] e_addr, e_wdata;
        e_en    = |v.gnt;
        e_we    = |(v.gnt & v.we);
        e_addr  = v.gnt[0] ? v.a0 : (v.gnt[1] ? v.a1 : 32'h0);
        e_wdata = v.gnt[0] ? W0 : (v.gnt[1] ? W1 : 32'h0);
        n_vec++;
        if (gnt !== v.gnt || rvalid !== v.rvalid || rdata !== v.rdata ||
            lock_abort !== v.abort || mem_en !== e_en || mem_we !== e_we ||
            mem_addr !== e_addr || mem_wdata !== e_wdata) begin
            n_err++;
            $display("FAIL %s: got gnt=%b rvalid=%b rdata=%h abort=%b en=%b we=%b addr=%h wdata=%h; want gnt=%b rvalid=%b rdata=%h abort=%b en=%b we=%b addr=%h wdata=%h",
                     name, gnt, rvalid, rdata, lock_abort, mem_en, mem_we, mem_addr, mem_wdata,
                     v.gnt, v.rvalid, v.rdata, v.abort, e_en, e_we, e_addr, e_wdata);
        end
    endtask

    // Drive one cycle of inputs, check mid-cycle, advance to posedge+1.
    task automatic apply(input string name, input vec_t v);
        req       = v.req;
        req_we    = v.we;
        req_lock  = v.lock;
        req_addr  = {v.a1, v.a0};
        req_wdata = {W1, W0};
        #3;
        check(name, v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t z;
        reset     = 1'b0;
        req       = 2'b00;
        req_we    = 2'b00;
        req_lock  = 2'b00;
        req_addr  = 64'h0;
        req_wdata = 64'h0;

        //            req    we     lock   a0     a1     gnt    rvalid rdata         abort
        tbl[0]  = mk(2'b11, 2'b11, 2'b00, 32'h08, 32'h88, 2'b01, 2'b00, 32'h0,        1'b0);
        tbl[1]  = mk(2'b11, 2'b11, 2'b00, 32'h08, 32'h88, 2'b10, 2'b00, 32'h0,        1'b0);
        tbl[2]  = mk(2'b11, 2'b11, 2'b00, 32'h08, 32'h88, 2'b01, 2'b00, 32'h0,        1'b0);
        tbl[3]  = mk(2'b11, 2'b11, 2'b00, 32'h08, 32'h88, 2'b10, 2'b00, 32'h0,        1'b0);
        tbl[4]  = mk(2'b11, 2'b11, 2'b00, 32'h08, 32'h88, 2'b01, 2'b00, 32'h0,        1'b0);
        tbl[5]  = mk(2'b11, 2'b11, 2'b00, 32'h08, 32'h88, 2'b10, 2'b00, 32'h0,        1'b0);
        tbl[6]  = mk(2'b10, 2'b00, 2'b00, 32'h00, 32'h40, 2'b10, 2'b00, 32'h0,        1'b0);
        tbl[7]  = mk(2'b01, 2'b00, 2'b00, 32'h44, 32'h00, 2'b01, 2'b00, 32'h0,        1'b0);
        tbl[8]  = mk(2'b00, 2'b00, 2'b00, 32'h00, 32'h00, 2'b00, 2'b10, 32'hDEADBEEF, 1'b0);
        tbl[9]  = mk(2'b00, 2'b00, 2'b00, 32'h00, 32'h00, 2'b00, 2'b01, 32'h12345678, 1'b0);
        tbl[10] = mk(2'b10, 2'b11, 2'b00, 32'h00, 32'h90, 2'b10, 2'b00, 32'h0,        1'b0);
        tbl[11] = mk(2'b11, 2'b11, 2'b01, 32'h10, 32'h94, 2'b01, 2'b00, 32'h0,        1'b0);
        tbl[12] = mk(2'b11, 2'b11, 2'b01, 32'h10, 32'h94, 2'b01, 2'b00, 32'h0,        1'b0);
        tbl[13] = mk(2'b11, 2'b11, 2'b01, 32'h10, 32'h94, 2'b01, 2'b00, 32'h0,        1'b0);
        tbl[14] = mk(2'b11, 2'b11, 2'b00, 32'h10, 32'h94, 2'b10, 2'b00, 32'h0,        1'b0);
        tbl[15] = mk(2'b01, 2'b11, 2'b00, 32'h10, 32'h94, 2'b01, 2'b00, 32'h0,        1'b0);
        tbl[16] = mk(2'b00, 2'b00, 2'b00, 32'h00, 32'h00, 2'b00, 2'b00, 32'h0,        1'b0);
        tbl[17] = mk(2'b11, 2'b11, 2'b00, 32'h20, 32'hA0, 2'b10, 2'b00, 32'h0,        1'b0);
        tbl[18] = mk(2'b11, 2'b11, 2'b01, 32'h20, 32'hA0, 2'b01, 2'b00, 32'h0,        1'b0);
        tbl[19] = mk(2'b11, 2'b11, 2'b01, 32'h20, 32'hA0, 2'b01, 2'b00, 32'h0,        1'b0);
        tbl[20] = mk(2'b11, 2'b11, 2'b01, 32'h20, 32'hA0, 2'b01, 2'b00, 32'h0,        1'b0);
        tbl[21] = mk(2'b11, 2'b11, 2'b01, 32'h20, 32'hA0, 2'b01, 2'b00, 32'h0,        1'b0);
        tbl[22] = mk(2'b11, 2'b11, 2'b01, 32'h20, 32'hA0, 2'b10, 2'b00, 32'h0,        1'b1);
        tbl[23] = mk(2'b11, 2'b11, 2'b01, 32'h20, 32'hA0, 2'b01, 2'b00, 32'h0,        1'b0);
        tbl[24] = mk(2'b11, 2'b11, 2'b00, 32'h20, 32'hA0, 2'b10, 2'b00, 32'h0,        1'b0);

        z = mk(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0);

        // Reset held with random requests: every output must stay zero.
        repeat (3) begin
            @(posedge clk);
            #1;
            req      = 2'($urandom);
            req_we   = 2'($urandom);
            req_lock = 2'($urandom);
            req_addr = {$urandom, $urandom};
            #3;
            check("reset_hold", z);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Fairness, read tagging, lock, forced release.
        for (int i = 0; i < 25; i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset one cycle after a read grant: that read never returns.
        apply("rst_rd_grant", mk(2'b01, 2'b00, 2'b00, 32'h40, 32'h0, 2'b01, 2'b00, 32'h0, 1'b0));
        reset = 1'b0;
        req   = 2'b00;
        #3;
        check("rst_mid", z);
        repeat (2) begin
            @(posedge clk);
            #1;
            req = 2'($urandom);
            #3;
            check("rst_mid_hold", z);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) apply("post_rst_idle", z);
        apply("post_rst_first", mk(2'b11, 2'b00, 2'b00, 32'h30, 32'hB0, 2'b01, 2'b00, 32'h0, 1'b0));
        apply("post_rst_wait", z);
        apply("post_rst_rdata", mk(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b01, 32'h1000_000C, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
